ast_width_narrower: RTL and testbench
=====================================

AST_WIDTH_NARROWER -- requirements
Module: ast_width_narrower

Interface
REQ-001 SHALL have parameter DATA_IN_W, default 128, input data width in bits.
REQ-002 SHALL have parameter DATA_OUT_W, default 64, output data width in bits.
REQ-003 SHALL have parameter CHANNEL_W, default 10, channel width.
REQ-004 SHALL have parameter EMPTY_IN_W, default $clog2(DATA_IN_W/8), or 1 if that is 0; input empty width.
REQ-005 SHALL have parameter EMPTY_OUT_W, default $clog2(DATA_OUT_W/8), or 1 if that is 0; output empty width.
REQ-006 clk_i  input  1  single clock; all logic on rising edge.
REQ-007 srst_i  input  1  reset, synchronous, active-high.
REQ-008 ast_data_i  input  DATA_IN_W  wide sink data; first symbol in MSBs.
REQ-009 ast_startofpacket_i / ast_endofpacket_i / ast_valid_i  input  1 each  sink framing and valid.
REQ-010 ast_empty_i  input  EMPTY_IN_W  unused bytes on eop beat.
REQ-011 ast_channel_i  input  CHANNEL_W  sink channel.
REQ-012 ast_ready_o  output  1  sink ready, ready latency 0.
REQ-013 ast_data_o  output  DATA_OUT_W  narrow source data.
REQ-014 ast_startofpacket_o / ast_endofpacket_o / ast_valid_o  output  1 each  source framing and valid.
REQ-015 ast_empty_o  output  EMPTY_OUT_W  unused bytes on source eop beat.
REQ-016 ast_channel_o  output  CHANNEL_W  source channel.
REQ-017 ast_ready_i  input  1  source ready, ready latency 0.

Function
REQ-018 DATA_IN_W SHALL be an integer multiple of DATA_OUT_W; both SHALL be multiples of 8. N = DATA_IN_W/DATA_OUT_W, OB = DATA_OUT_W/8.
REQ-019 Input beat accepted iff ast_valid_i && ast_ready_o; on acceptance, data, sop, eop, empty and channel SHALL be registered into a one-beat buffer.
REQ-020 Two states: IDLE (buffer empty) and SEND (buffer full, slice counter k of width max($clog2(N),1)).
REQ-021 Slice k SHALL be ast_data_i[DATA_IN_W-1-k*DATA_OUT_W -: DATA_OUT_W]; slices emitted in order k = 0, 1, ...
REQ-022 Non-eop beat: all N slices emitted, input empty ignored. Eop beat: bytes B = DATA_IN_W/8 - empty; slices M = ceil(B/OB); slices M..N-1 dropped.
REQ-023 ast_startofpacket_o SHALL be 1 only on slice 0 of a beat with sop=1.
REQ-024 ast_endofpacket_o SHALL be 1 only on slice M-1 of an eop beat.
REQ-025 ast_empty_o SHALL be M*OB - B on the eop slice and 0 otherwise.
REQ-026 ast_channel_o SHALL equal the buffered channel on every slice.
REQ-027 ast_valid_o = SEND; k advances on ast_valid_o && ast_ready_i.
REQ-028 While ast_valid_o && !ast_ready_i, all source outputs SHALL hold stable.
REQ-029 ast_ready_o = IDLE || (last slice && ast_ready_i), combinational from ast_ready_i; a new beat SHALL be loaded in the same cycle the last slice transfers (no bubble).
REQ-030 Latency: beat accepted at cycle t -> slice 0 valid at t+1; sustained throughput one slice per cycle.
REQ-031 Last slice transfers with no new input -> IDLE next cycle, ast_valid_o = 0.
REQ-032 No packet-framing checks; sop/eop pass through as received.

Reset
REQ-033 While srst_i = 1: state IDLE, k = 0, ast_valid_o, ast_startofpacket_o, ast_endofpacket_o = 0; ast_data_o, ast_empty_o, ast_channel_o = 0; ast_ready_o = 0.
REQ-034 ast_ready_o SHALL be 1 in the first cycle after srst_i deasserts.
REQ-035 Reset mid-packet SHALL discard buffered slices; no partial output after reset.

Verification
REQ-036 Defaults, sop=eop=1, empty=0, data=0x00112233445566778899AABBCCDDEEFF, ch=5 -> 0x0011223344556677 sop=1 eop=0, then 0x8899AABBCCDDEEFF sop=0 eop=1 empty=0, ch=5 on both.
REQ-037 Eop beat, empty=9 (B=7) -> one slice, eop=1, empty=1, upper 7 bytes of input.
REQ-038 Eop beat, empty=8 -> one slice, eop=1, empty=0; second slice never presented.
REQ-039 ast_ready_i low 3 cycles during slice 0 -> outputs stable all 3 cycles, ast_ready_o = 0, slice 1 follows after ready rises.
REQ-040 3-beat packet, valid continuous, ast_ready_i = 1 -> 6 slices on 6 consecutive cycles, sop only first, eop only last.
REQ-041 srst_i pulsed while slice 1 of a beat is pending -> ast_valid_o = 0 next cycle, ast_ready_o = 1 the cycle after reset releases, no stale slice emitted.

Source files
------------

// File: rtl/ast_width_narrower.sv
// Avalon-ST width narrower: buffers one wide beat and replays it as N narrow
// slices, MSB slice first. A trailing eop beat is trimmed by its empty count.
module ast_width_narrower #(
  parameter int DATA_IN_W   = 128,
  parameter int DATA_OUT_W  = 64,
  parameter int CHANNEL_W   = 10,
  parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W/8)  == 0) ? 1 : $clog2(DATA_IN_W/8),
  parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W/8) == 0) ? 1 : $clog2(DATA_OUT_W/8)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,

  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,

  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int N        = DATA_IN_W / DATA_OUT_W;
  localparam int OB       = DATA_OUT_W / 8;
  localparam int IN_BYTES = DATA_IN_W / 8;
  localparam int KW       = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]             state;
  logic [KW-1:0]          k;
  logic [KW-1:0]          last_k;
  logic [DATA_IN_W-1:0]   data_buf;
  logic                   sop_buf;
  logic                   eop_buf;
  logic [EMPTY_OUT_W-1:0] empty_buf;
  logic [CHANNEL_W-1:0]   ch_buf;

  logic [31:0]            byte_cnt;
  logic [31:0]            slice_cnt;
  logic [31:0]            pad_cnt;
  logic [KW-1:0]          load_last;
  logic [EMPTY_OUT_W-1:0] load_empty;

  logic send;
  logic last_slice;
  logic load;
  logic advance;

  // Slice count and trailing pad are resolved at load time so the replay
  // path only compares k against a stored index.
  // NOTE: every always_comb output gets a value before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    byte_cnt  = 32'(IN_BYTES) - 32'(ast_empty_i);
    slice_cnt = (byte_cnt + 32'(OB - 1)) / 32'(OB);
    if (slice_cnt == 32'd0)     slice_cnt = 32'd1;
    if (slice_cnt > 32'(N))     slice_cnt = 32'(N);
    pad_cnt    = slice_cnt * 32'(OB) - byte_cnt;
    load_last  = ast_endofpacket_i ? KW'(slice_cnt - 32'd1) : KW'(N - 1);
    load_empty = ast_endofpacket_i ? EMPTY_OUT_W'(pad_cnt) : '0;
  end

  assign send        = (state == SEND);
  assign last_slice  = (k == last_k);
  assign ast_valid_o = send && !srst_i;
  assign ast_ready_o = !srst_i && (!send || (last_slice && ast_ready_i));
  assign load        = ast_valid_i && ast_ready_o;
  assign advance     = ast_valid_o && ast_ready_i;

  // NOTE: the beat buffer is cleared on reset along with the control state
  // so zeroed outputs never depend on gating alone after reset releases.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state     <= IDLE;
      k         <= '0;
      last_k    <= '0;
      data_buf  <= '0;
      sop_buf   <= 1'b0;
      eop_buf   <= 1'b0;
      empty_buf <= '0;
      ch_buf    <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, independent of statement order.
      state     <= SEND;
      k         <= '0;
      last_k    <= load_last;
      data_buf  <= ast_data_i;
      sop_buf   <= ast_startofpacket_i;
      eop_buf   <= ast_endofpacket_i;
      empty_buf <= load_empty;
      ch_buf    <= ast_channel_i;
    end else if (advance) begin
      if (last_slice) begin
        state <= IDLE;
        k     <= '0;
      end else begin
        k <= k + KW'(1);
      end
      // Shift so the next slice always sits in the top DATA_OUT_W bits.
      data_buf <= data_buf << DATA_OUT_W;
    end
  end

  assign ast_data_o          = ast_valid_o ? data_buf[DATA_IN_W-1 -: DATA_OUT_W] : '0;
  assign ast_startofpacket_o = ast_valid_o && sop_buf && (k == '0);
  assign ast_endofpacket_o   = ast_valid_o && eop_buf && last_slice;
  assign ast_empty_o         = ast_endofpacket_o ? empty_buf : '0;
  assign ast_channel_o       = ast_valid_o ? ch_buf : '0;

endmodule

// File: tb/tb_ast_width_narrower.sv
// Scoreboard bench for ast_width_narrower at default widths (128 -> 64).
module tb_ast_width_narrower;

  localparam int DIN  = 128;
  localparam int DOUT = 64;
  localparam int N    = DIN / DOUT;
  localparam int OB   = DOUT / 8;

  typedef struct {
    logic [DOUT-1:0] data;
    logic            sop;
    logic            eop;
    logic [2:0]      empty;
    logic [9:0]      ch;
  } slice_t;

  logic            clk_i;
  logic            srst_i;
  logic [DIN-1:0]  ast_data_i;
  logic            ast_startofpacket_i;
  logic            ast_endofpacket_i;
  logic            ast_valid_i;
  logic [3:0]      ast_empty_i;
  logic [9:0]      ast_channel_i;
  logic            ast_ready_o;
  logic [DOUT-1:0] ast_data_o;
  logic            ast_startofpacket_o;
  logic            ast_endofpacket_o;
  logic            ast_valid_o;
  logic [2:0]      ast_empty_o;
  logic [9:0]      ast_channel_o;
  logic            ast_ready_i;

  logic ready_man;
  logic rnd_bit;
  logic rand_bp;

  int     checks;
  int     failures;
  int     cyc;
  slice_t sb[$];
  int     xfer_cyc[$];
  slice_t exp_s;

  assign ast_ready_i = rand_bp ? rnd_bit : ready_man;

  ast_width_narrower dut (
    .clk_i               (clk_i),
    .srst_i              (srst_i),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  always begin
    @(posedge clk_i);
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected slices of one accepted beat, derived from the byte/empty rules.
  task automatic push_beat(input logic [DIN-1:0] d, input logic s, input logic e,
                           input logic [3:0] emp, input logic [9:0] ch);
    int b, m, ns;
    slice_t t;
    b  = DIN / 8 - int'(emp);
    m  = (b + OB - 1) / OB;
    ns = e ? m : N;
    for (int i = 0; i < ns; i++) begin
      t.data  = DOUT'(d >> ((N - 1 - i) * DOUT));
      t.sop   = s && (i == 0);
      t.eop   = e && (i == ns - 1);
      t.empty = (e && (i == ns - 1)) ? 3'(m * OB - b) : 3'd0;
      t.ch    = ch;
      sb.push_back(t);
    end
  endtask

  always @(negedge clk_i) begin
    if (ast_valid_o && ast_ready_i) begin
      xfer_cyc.push_back(cyc);
      check("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_s = sb.pop_front();
        check("slice_data",  ast_data_o,          exp_s.data);
        check("slice_sop",   ast_startofpacket_o, exp_s.sop);
        check("slice_eop",   ast_endofpacket_o,   exp_s.eop);
        check("slice_empty", ast_empty_o,         exp_s.empty);
        check("slice_ch",    ast_channel_o,       exp_s.ch);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [DIN-1:0] d, input logic s, input logic e,
                           input logic [3:0] emp, input logic [9:0] ch, input bit hold);
    int n;
    n = 0;
    ast_data_i          = d;
    ast_startofpacket_i = s;
    ast_endofpacket_i   = e;
    ast_empty_i         = emp;
    ast_channel_i       = ch;
    ast_valid_i         = 1'b1;
    @(negedge clk_i);
    while (!ast_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("accept_timeout", ast_ready_o, 1);
    if (ast_ready_o) push_beat(d, s, e, emp, ch);
    @(posedge clk_i);
    #1;
    if (!hold) ast_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ast_valid_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_sb", sb.size(), 0);
    check("drain_valid", ast_valid_o, 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DIN-1:0] d;
    logic           in_pkt;
    logic           e;
    bit             hold;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    rand_bp  = 1'b0;
    rnd_bit  = 1'b1;
    ready_man = 1'b1;
    srst_i   = 1'b1;
    ast_data_i = '0;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i   = 1'b0;
    ast_valid_i   = 1'b0;
    ast_empty_i   = '0;
    ast_channel_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", ast_valid_o, 0);
    check("rst_ready", ast_ready_o, 0);
    check("rst_data",  ast_data_o, 0);
    check("rst_sop",   ast_startofpacket_o, 0);
    check("rst_eop",   ast_endofpacket_o, 0);
    check("rst_empty", ast_empty_o, 0);
    check("rst_ch",    ast_channel_o, 0);
    @(posedge clk_i);
    #1;
    srst_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_rst", ast_ready_o, 1);
    @(posedge clk_i);
    #1;

    // Single-beat packet, full width, with first-slice latency
    send_beat(128'h00112233445566778899AABBCCDDEEFF, 1'b1, 1'b1, 4'd0, 10'd5, 1'b0);
    check("latency_valid", ast_valid_o, 1);
    check("basic_slice0",  ast_data_o, 64'h0011223344556677);
    wait_drain();

    // eop with 7 valid bytes: one slice, one pad byte
    xfer_cyc.delete();
    send_beat(128'hA1A2A3A4A5A6A7A8B1B2B3B4B5B6B7B8, 1'b1, 1'b1, 4'd9, 10'd1, 1'b0);
    wait_drain();
    check("empty9_nslices", xfer_cyc.size(), 1);

    // eop with exactly 8 valid bytes: one slice, no pad
    xfer_cyc.delete();
    send_beat(128'hC1C2C3C4C5C6C7C8D1D2D3D4D5D6D7D8, 1'b1, 1'b1, 4'd8, 10'd2, 1'b0);
    wait_drain();
    check("empty8_nslices", xfer_cyc.size(), 1);

    // Backpressure on slice 0 for three cycles
    xfer_cyc.delete();
    ready_man = 1'b0;
    send_beat(128'h0F0E0D0C0B0A09080706050403020100, 1'b1, 1'b0, 4'd0, 10'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_valid", ast_valid_o, 1);
      check("bp_data",  ast_data_o, 64'h0F0E0D0C0B0A0908);
      check("bp_sop",   ast_startofpacket_o, 1);
      check("bp_ch",    ast_channel_o, 7);
      check("bp_ready", ast_ready_o, 0);
      @(posedge clk_i);
      #1;
    end
    ready_man = 1'b1;
    wait_drain();
    check("bp_nslices", xfer_cyc.size(), 2);

    // Three back-to-back beats: six slices on consecutive cycles
    xfer_cyc.delete();
    send_beat(128'h11111111111111112222222222222222, 1'b1, 1'b0, 4'd0, 10'd3, 1'b1);
    send_beat(128'h33333333333333334444444444444444, 1'b0, 1'b0, 4'd0, 10'd3, 1'b1);
    send_beat(128'h55555555555555556666666666666666, 1'b0, 1'b1, 4'd0, 10'd3, 1'b0);
    wait_drain();
    check("b2b_nslices", xfer_cyc.size(), 6);
    if (xfer_cyc.size() == 6)
      check("b2b_span", xfer_cyc[5] - xfer_cyc[0], 5);

    // Reset while slice 1 is pending
    send_beat(128'hDEADBEEFCAFEF00D0123456789ABCDEF, 1'b1, 1'b0, 4'd0, 10'd9, 1'b0);
    @(posedge clk_i);
    #1;
    ready_man = 1'b0;
    srst_i    = 1'b1;
    sb.delete();
    @(negedge clk_i);
    check("midrst_valid", ast_valid_o, 0);
    check("midrst_ready", ast_ready_o, 0);
    @(posedge clk_i);
    #1;
    srst_i    = 1'b0;
    ready_man = 1'b1;
    @(negedge clk_i);
    check("midrst_ready_after", ast_ready_o, 1);
    check("midrst_valid_after", ast_valid_o, 0);
    xfer_cyc.delete();
    repeat (4) @(negedge clk_i);
    check("midrst_no_stale", xfer_cyc.size(), 0);
    @(posedge clk_i);
    #1;

    // Random packets under random backpressure
    rand_bp = 1'b1;
    in_pkt  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d    = {$urandom, $urandom, $urandom, $urandom};
      e    = ($urandom_range(0, 2) == 0) || (i == 23);
      hold = ($urandom_range(0, 1) == 1) && (i != 23);
      send_beat(d, !in_pkt, e, 4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)), hold);
      in_pkt = !e;
    end
    wait_drain();
    rand_bp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
